// File: rtl/sound_event_arbiter.sv
// Fixed-priority arbiter that shares one speaker pin among four game-event tone requesters.
// Optional feature: define SOUND_PREEMPT_EN to let a higher-priority request cut a playing tone short.
module sound_event_arbiter #(
    parameter int unsigned TONE0_HALF = 12500,
    parameter int unsigned TONE1_HALF = 18939,
    parameter int unsigned TONE2_HALF = 28409,
    parameter int unsigned TONE3_HALF = 56818,
    parameter int unsigned DUR_CYCLES = 2500000,
    parameter int unsigned GAP_CYCLES = 250000
) (
    input  logic       clk25,
    input  logic       Reset,
    input  logic [3:0] req,
    input  logic       enable,
    output logic       Speaker,
    output logic       busy,
    output logic [1:0] active_id,
    output logic [3:0] grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [23:0] C_DUR_LOAD = 24'(DUR_CYCLES - 1);
    localparam logic [23:0] C_GAP_LOAD = 24'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_busy;
    logic [3:0]  r_pending;
    logic [1:0]  r_active_id;
    logic [3:0]  r_grant;
    logic        r_speaker;
    logic [23:0] r_half_cnt;
    logic [23:0] r_dur_cnt;
    logic [23:0] r_gap_cnt;

    logic        w_pend_any;
    logic [1:0]  w_sel_id;
    logic        w_preempt;
    logic        w_start;
    logic [3:0]  w_clear;
    logic [3:0]  w_grant_next;
    logic [1:0]  w_active_next;
    logic        w_speaker_next;
    logic [23:0] w_half_next;
    logic [23:0] w_dur_next;
    logic [23:0] w_gap_next;

    function automatic logic [23:0] f_half_load(input logic [1:0] id);
        case (id)
            2'd0:    return 24'(TONE0_HALF - 1);
            2'd1:    return 24'(TONE1_HALF - 1);
            2'd2:    return 24'(TONE2_HALF - 1);
            default: return 24'(TONE3_HALF - 1);
        endcase
    endfunction

    // Bit 0 is the highest priority.
    function automatic logic [1:0] f_lowest(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign w_pend_any = |r_pending;
    assign w_sel_id   = f_lowest(r_pending);

`ifdef SOUND_PREEMPT_EN
    assign w_preempt = w_pend_any && (w_sel_id < r_active_id);
`else
    assign w_preempt = 1'b0;
`endif

    // State register; busy is registered alongside so it tracks the state exactly.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    // Next-state logic; w_start marks an edge that grants a requester and (re)enters PLAY.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pend_any) begin
                        w_state_next = ST_PLAY;
                        w_start      = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_preempt) begin
                        w_start = 1'b1;
                    end else if (r_dur_cnt == '0) begin
                        w_state_next = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output logic: next values of the grant pulse, tone generator and counters.
    always_comb begin
        w_grant_next   = 4'b0000;
        w_clear        = enable ? 4'b0000 : 4'b1111;
        w_active_next  = r_active_id;
        w_speaker_next = 1'b0;
        w_half_next    = r_half_cnt;
        w_dur_next     = r_dur_cnt;
        w_gap_next     = r_gap_cnt;
        if (w_start) begin
            w_grant_next  = 4'b0001 << w_sel_id;
            w_clear       = 4'b0001 << w_sel_id;
            w_active_next = w_sel_id;
            w_half_next   = f_half_load(w_sel_id);
            w_dur_next    = C_DUR_LOAD;
        end else if (w_state_next == ST_PLAY) begin
            w_dur_next = r_dur_cnt - 24'd1;
            if (r_half_cnt == '0) begin
                w_speaker_next = ~r_speaker;
                w_half_next    = f_half_load(r_active_id);
            end else begin
                w_speaker_next = r_speaker;
                w_half_next    = r_half_cnt - 24'd1;
            end
        end else if (r_state == ST_PLAY && w_state_next == ST_GAP) begin
            w_gap_next = C_GAP_LOAD;
        end else if (r_state == ST_GAP && w_state_next == ST_GAP) begin
            w_gap_next = r_gap_cnt - 24'd1;
        end
    end

    // A request arriving on its own grant edge survives because the set term is OR-ed in last.
    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            r_pending   <= 4'b0000;
            r_active_id <= 2'd0;
            r_grant     <= 4'b0000;
            r_speaker   <= 1'b0;
            r_half_cnt  <= '0;
            r_dur_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_pending   <= (r_pending & ~w_clear) | (req & {4{enable}});
            r_active_id <= w_active_next;
            r_grant     <= w_grant_next;
            r_speaker   <= w_speaker_next;
            r_half_cnt  <= w_half_next;
            r_dur_cnt   <= w_dur_next;
            r_gap_cnt   <= w_gap_next;
        end
    end

    assign Speaker   = r_speaker;
    assign busy      = r_busy;
    assign active_id = r_active_id;
    assign grant     = r_grant;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Self-checking bench for sound_event_arbiter: directed scenarios plus random traffic against
// an elapsed-time reference model. Honours SOUND_PREEMPT_EN when the design is built with it.
module tb_sound_event_arbiter;

    localparam int DUR = 16;
    localparam int GAP = 4;
`ifdef SOUND_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk25 = 1'b0;
    logic       Reset;
    logic [3:0] req;
    logic       enable;
    logic       Speaker;
    logic       busy;
    logic [1:0] active_id;
    logic [3:0] grant;

    sound_event_arbiter #(
        .TONE0_HALF(2),
        .TONE1_HALF(3),
        .TONE2_HALF(4),
        .TONE3_HALF(5),
        .DUR_CYCLES(DUR),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk25    (clk25),
        .Reset    (Reset),
        .req      (req),
        .enable   (enable),
        .Speaker  (Speaker),
        .busy     (busy),
        .active_id(active_id),
        .grant    (grant)
    );

    always #5 clk25 = ~clk25;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int g_ok;

    // Reference model: which phase we are in and how many cycles have elapsed in it.
    typedef enum int {M_IDLE, M_PLAY, M_GAP} mode_t;
    mode_t      m_mode;
    int         m_n;
    logic [1:0] m_id;
    logic [3:0] m_pend;
    logic [3:0] m_grant;

    function automatic int half_of(input logic [1:0] id);
        return int'(id) + 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_n     = 0;
        m_id    = 2'd0;
        m_pend  = 4'b0000;
        m_grant = 4'b0000;
    endtask

    // One clock edge of the reference behaviour, given the inputs present at that edge.
    task automatic model_edge(input logic [3:0] r, input logic en);
        logic [3:0] clr;
        int         k;
        clr     = 4'b0000;
        m_grant = 4'b0000;
        k       = 4;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) k = i;
        if (!en) begin
            m_mode = M_IDLE;
            m_n    = 0;
            m_pend = 4'b0000;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (k < 4) begin
                        m_grant[k] = 1'b1;
                        clr[k]     = 1'b1;
                        m_id       = 2'(k);
                        m_mode     = M_PLAY;
                        m_n        = 0;
                    end
                end
                M_PLAY: begin
                    if (PREEMPT && k < int'(m_id)) begin
                        m_grant[k] = 1'b1;
                        clr[k]     = 1'b1;
                        m_id       = 2'(k);
                        m_n        = 0;
                    end else if (m_n == DUR - 1) begin
                        m_mode = M_GAP;
                        m_n    = 0;
                    end else begin
                        m_n++;
                    end
                end
                default: begin
                    if (m_n == GAP - 1) begin
                        m_mode = M_IDLE;
                        m_n    = 0;
                    end else begin
                        m_n++;
                    end
                end
            endcase
            m_pend = (m_pend & ~clr) | r;
        end
    endtask

    task automatic compare_outputs();
        int exp_spk;
        exp_spk = (m_mode == M_PLAY) ? ((m_n / half_of(m_id)) % 2) : 0;
        check("speaker",   32'(Speaker),   32'(exp_spk));
        check("busy",      32'(busy),      32'(m_mode != M_IDLE));
        check("grant",     32'(grant),     32'(m_grant));
        check("active_id", 32'(active_id), 32'(m_id));
    endtask

    // Inputs change on the falling edge; the DUT is compared on the next falling edge.
    task automatic cycle(input logic [3:0] r, input logic en);
        req    = r;
        enable = en;
        @(posedge clk25);
        model_edge(r, en);
        cyc++;
        @(negedge clk25);
        compare_outputs();
    endtask

    task automatic settle();
        for (int i = 0; i < 100; i++) begin
            if (!busy && m_mode == M_IDLE && m_pend == 4'b0000) break;
            cycle(4'b0000, 1'b1);
        end
        check("settle_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_grant();
        g_ok = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(4'b0000, 1'b1);
            if (grant != 4'b0000) begin
                g_ok = 1;
                break;
            end
        end
        check("grant_wait", 32'(g_ok), 32'd1);
    endtask

    initial begin
        int t1, t3, cnt, cnt3, d;
        Reset  = 1'b1;
        req    = 4'b0000;
        enable = 1'b0;
        model_reset();
        repeat (2) @(negedge clk25);
        compare_outputs();
        Reset = 1'b0;

        // Single request on the 440 Hz-style channel.
        settle();
        cycle(4'b0100, 1'b1);
        wait_grant();
        check("single_grant", 32'(grant), 32'h4);
        check("single_id", 32'(active_id), 32'd2);
        repeat (30) cycle(4'b0000, 1'b1);

        // Simultaneous requests: req[1] first, req[3] exactly DUR+GAP+1 later.
        settle();
        cycle(4'b1010, 1'b1);
        t1 = -100;
        t3 = 0;
        for (int i = 0; i < 70; i++) begin
            cycle(4'b0000, 1'b1);
            if (grant[1]) t1 = i;
            if (grant[3]) t3 = i;
        end
        check("sim_spacing", 32'(t3 - t1), 32'd21);

        // Repeated req[0] during another tone collapses into one grant.
        settle();
        cycle(4'b0100, 1'b1);
        wait_grant();
        for (int i = 0; i < 12; i++)
            cycle((i == 2 || i == 5 || i == 9) ? 4'b0001 : 4'b0000, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(4'b0000, 1'b1);
            if (grant[0]) cnt++;
        end
        check("collapse_cnt", 32'(cnt), 32'd1);

        // req[0] held through its own grant edge re-arms for a second grant.
        settle();
        cnt = 0;
        cycle(4'b0001, 1'b1);
        cycle(4'b0001, 1'b1);
        check("rearm_first", 32'(grant), 32'h1);
        if (grant[0]) cnt++;
        for (int i = 0; i < 50; i++) begin
            cycle(4'b0000, 1'b1);
            if (grant[0]) cnt++;
        end
        check("rearm_cnt", 32'(cnt), 32'd2);

        // Mute mid-tone while Speaker is high and another request is pending.
        settle();
        cycle(4'b0100, 1'b1);
        wait_grant();
        repeat (3) cycle(4'b0000, 1'b1);
        cycle(4'b0010, 1'b1);
        cycle(4'b0000, 1'b0);
        check("mute_busy", 32'(busy), 32'd0);
        check("mute_spk", 32'(Speaker), 32'd0);
        repeat (3) cycle(4'b1111, 1'b0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(4'b0000, 1'b1);
            if (grant != 4'b0000) cnt++;
        end
        check("mute_nogrant", 32'(cnt), 32'd0);

        // Low-priority tone interrupted (or not) by req[0] on PLAY cycle 6.
        settle();
        cycle(4'b1000, 1'b1);
        wait_grant();
        repeat (5) cycle(4'b0000, 1'b1);
        cycle(4'b0001, 1'b1);
        d    = -1;
        cnt3 = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(4'b0000, 1'b1);
            if (grant[0] && d < 0) d = i;
            if (grant[3]) cnt3++;
        end
        check("preempt_delay", 32'(d), PREEMPT ? 32'd1 : 32'd15);
        check("no_replay3", 32'(cnt3), 32'd0);

        // Random traffic with occasional mute.
        settle();
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] r;
            logic       en;
            r  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            en = ($urandom_range(0, 99) != 0);
            cycle(r, en);
        end

        // Asynchronous reset while the speaker is high; the pending req[1] must be lost.
        settle();
        cycle(4'b0100, 1'b1);
        wait_grant();
        cycle(4'b0010, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (Speaker) break;
            cycle(4'b0000, 1'b1);
        end
        check("spk_wait", 32'(Speaker), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("rst_spk",    32'(Speaker),   32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_grant",  32'(grant),     32'd0);
        check("rst_active", 32'(active_id), 32'd0);
        model_reset();
        @(negedge clk25);
        Reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(4'b0000, 1'b1);
            if (grant != 4'b0000) cnt++;
        end
        check("rst_pending_lost", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
